// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter and its load-path converter.
package gray_pkg;

   localparam int unsigned GRAY_MAX_W = 32;

   typedef logic [GRAY_MAX_W-1:0] gword_t;

   function automatic gword_t bin2gray_f(input gword_t b);
      return b ^ (b >> 1);
   endfunction

   // A zero-extended code converts correctly at any width up to GRAY_MAX_W.
   function automatic gword_t gray2bin_f(input gword_t g);
      gword_t b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = int'(GRAY_MAX_W) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic gword_t max_val_f(input int unsigned w);
      return gword_t'({GRAY_MAX_W{1'b1}} >> (GRAY_MAX_W - w));
   endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Width-generic Gray-to-binary converter: XOR prefix chain from the MSB down.
module gray2bin_n #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   logic w_acc;

   always_comb begin
      o_bin = '0;
      w_acc = 1'b0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         w_acc    = w_acc ^ i_gray[i];
         o_bin[i] = w_acc;
      end
   end

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with Gray-coded load, wrap or saturate at the bounds.
module gray_counter #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned RESET_VAL = 0,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             wrap
);

   import gray_pkg::*;

   localparam logic [WIDTH-1:0] MAX_BIN  = WIDTH'(max_val_f(WIDTH));
   localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray_f(gword_t'(RESET_VAL)));

   generate
      if (WIDTH < 2 || WIDTH > GRAY_MAX_W) begin : g_bad_width
         $error("gray_counter: WIDTH out of range");
      end
      if (gword_t'(RESET_VAL) > max_val_f(WIDTH)) begin : g_bad_reset
         $error("gray_counter: RESET_VAL does not fit in WIDTH");
      end
   endgenerate

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;

   logic [WIDTH-1:0] w_load_bin;
   logic [WIDTH-1:0] w_step_bin;
   logic [WIDTH-1:0] w_step_gray;
   logic             w_at_bound;

   gray2bin_n #(
      .WIDTH (WIDTH)
   ) u_load_conv (
      .i_gray (load_gray),
      .o_bin  (w_load_bin)
   );

   assign w_at_bound  = up ? (r_bin == MAX_BIN) : (r_bin == '0);
   assign w_step_bin  = up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
   assign w_step_gray = WIDTH'(bin2gray_f(gword_t'(w_step_bin)));

   // Priority rst > load > en; bin and gray always update on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin  <= RST_BIN;
         r_gray <= RST_GRAY;
         r_wrap <= 1'b0;
      end else if (load) begin
         r_bin  <= w_load_bin;
         r_gray <= load_gray;
         r_wrap <= 1'b0;
      end else if (en) begin
         if (SATURATE && w_at_bound) begin
            r_wrap <= 1'b0;
         end else begin
            r_bin  <= w_step_bin;
            r_gray <= w_step_gray;
            r_wrap <= w_at_bound;
         end
      end else begin
         r_wrap <= 1'b0;
      end
   end

   assign bin  = r_bin;
   assign gray = r_gray;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench: wrap, saturate and non-zero-reset counters driven by one stimulus.
module tb_gray_counter;

   logic       clk = 1'b0;
   logic       rst, en, up, load;
   logic [3:0] load_gray;

   logic [3:0] a_bin, a_gray, b_bin, b_gray, c_bin, c_gray;
   logic       a_wrap, b_wrap, c_wrap;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [3:0] GTAB [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                        4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                        4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                        4'b1010, 4'b1011, 4'b1001, 4'b1000};

   always #5 clk = ~clk;

   gray_counter #(.WIDTH(4), .RESET_VAL(0), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
      .bin(a_bin), .gray(a_gray), .wrap(a_wrap));

   gray_counter #(.WIDTH(4), .RESET_VAL(0), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
      .bin(b_bin), .gray(b_gray), .wrap(b_wrap));

   gray_counter #(.WIDTH(4), .RESET_VAL(5), .SATURATE(1'b0)) u_rv5 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
      .bin(c_bin), .gray(c_gray), .wrap(c_wrap));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] prev_gray;
      logic [3:0] kb;
      logic [3:0] cb;

      // Reset dominates load and enable.
      rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_gray = 4'b1111;
      step(); step();
      chk("rst_a_bin",  a_bin,  4'b0000);
      chk("rst_a_gray", a_gray, 4'b0000);
      chk("rst_a_wrap", a_wrap, 1'b0);
      chk("rst_c_bin",  c_bin,  4'b0101);
      chk("rst_c_gray", c_gray, 4'b0111);

      // Up sweep through a full period.
      rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
      prev_gray = a_gray;
      for (int k = 1; k <= 16; k++) begin
         step();
         kb = 4'(k);
         cb = 4'(k + 5);
         chk($sformatf("up_a_bin_%0d", k),  a_bin,  kb);
         chk($sformatf("up_a_gray_%0d", k), a_gray, GTAB[kb]);
         chk($sformatf("up_a_wrap_%0d", k), a_wrap, (k == 16));
         chk($sformatf("up_a_1bit_%0d", k), $countones(prev_gray ^ a_gray), 1);
         chk($sformatf("up_c_bin_%0d", k),  c_bin,  cb);
         chk($sformatf("up_c_wrap_%0d", k), c_wrap, (k == 11));
         prev_gray = a_gray;
      end
      chk("up_b_hold_bin",  b_bin,  4'b1111);
      chk("up_b_hold_wrap", b_wrap, 1'b0);

      // Direction change with no dead cycle, then down wrap.
      up = 1'b0;
      step();
      chk("dn_a_bin",  a_bin,  4'b1111);
      chk("dn_a_gray", a_gray, 4'b1000);
      chk("dn_a_wrap", a_wrap, 1'b1);
      chk("dn_b_bin",  b_bin,  4'b1110);
      step();
      chk("dn2_a_bin",  a_bin,  4'b1110);
      chk("dn2_a_gray", a_gray, 4'b1001);
      chk("dn2_a_wrap", a_wrap, 1'b0);
      chk("dn2_c_bin",  c_bin,  4'b0011);

      // Load beats enable.
      load = 1'b1; load_gray = 4'b1101; en = 1'b1; up = 1'b1;
      step();
      chk("ld_a_bin",  a_bin,  4'b1001);
      chk("ld_a_gray", a_gray, 4'b1101);
      chk("ld_a_wrap", a_wrap, 1'b0);
      chk("ld_b_bin",  b_bin,  4'b1001);
      load = 1'b0;
      step();
      chk("ld_up_bin",  a_bin,  4'b1010);
      chk("ld_up_gray", a_gray, 4'b1111);

      // Hold with enable low.
      en = 1'b0;
      step();
      chk("hold_bin",  a_bin,  4'b1010);
      chk("hold_gray", a_gray, 4'b1111);
      chk("hold_wrap", a_wrap, 1'b0);

      // Saturate at the top; the wrapping counter rolls over alongside.
      load = 1'b1; load_gray = 4'b1000;
      step();
      chk("ld15_b_bin", b_bin, 4'b1111);
      load = 1'b0; en = 1'b1; up = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("sat_b_bin_%0d", k),  b_bin,  4'b1111);
         chk($sformatf("sat_b_gray_%0d", k), b_gray, 4'b1000);
         chk($sformatf("sat_b_wrap_%0d", k), b_wrap, 1'b0);
         chk($sformatf("sat_a_wrap_%0d", k), a_wrap, (k == 1));
         chk($sformatf("sat_a_bin_%0d", k),  a_bin,  4'(k - 1));
      end
      up = 1'b0;
      step();
      chk("sat_dn_b_bin",  b_bin,  4'b1110);
      chk("sat_dn_b_gray", b_gray, 4'b1001);

      // Saturate at the bottom.
      load = 1'b1; load_gray = 4'b0000;
      step();
      load = 1'b0; en = 1'b1; up = 1'b0;
      step();
      chk("sat0_b_bin",  b_bin,  4'b0000);
      chk("sat0_b_gray", b_gray, 4'b0000);
      chk("sat0_b_wrap", b_wrap, 1'b0);
      chk("sat0_a_bin",  a_bin,  4'b1111);
      chk("sat0_a_wrap", a_wrap, 1'b1);

      // Reset mid-run restores RESET_VAL and counting resumes from it.
      load = 1'b1; load_gray = 4'b1010;
      step();
      chk("ld12_c_bin", c_bin, 4'b1100);
      load = 1'b0; en = 1'b1; up = 1'b1;
      step();
      chk("run_c_bin",  c_bin,  4'b1101);
      chk("run_c_gray", c_gray, 4'b1011);
      rst = 1'b1; load = 1'b1; load_gray = 4'b0110; en = 1'b1;
      step();
      chk("mrst_c_bin",  c_bin,  4'b0101);
      chk("mrst_c_gray", c_gray, 4'b0111);
      chk("mrst_c_wrap", c_wrap, 1'b0);
      chk("mrst_a_bin",  a_bin,  4'b0000);
      rst = 1'b0; load = 1'b0;
      step();
      chk("resume_c_bin",  c_bin,  4'b0110);
      chk("resume_c_gray", c_gray, 4'b0101);
      chk("resume_a_bin",  a_bin,  4'b0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
